approx_error_monitor: RTL and testbench

- Sequential evaluation stage directly downstream of a combinational approximate circuit (e.g. a 4-input, 3-output abs-diff approximation with error threshold 1).
- Sweeps the full input space into both the exact and the approximate circuit and consumes their outputs.
- Accumulates error statistics (max absolute error, mismatch count, error sum) and flags a threshold violation.
- Used in hardware-in-the-loop checks of generated approximations.

---
 rtl/approx_error_monitor.sv | 68 ++++++
 tb/tb_approx_error_monitor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/approx_error_monitor.sv
// approx_error_monitor: sweeps the input space through exact/approximate circuits and accumulates error statistics.
module approx_error_monitor #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [N_IN-1:0]       in_vec,
    input  logic [N_OUT-1:0]      exact_val,
    input  logic [N_OUT-1:0]      approx_val,
    output logic                  busy,
    output logic                  done,
    output logic [N_OUT-1:0]      max_err,
    output logic [N_IN:0]         err_count,
    output logic [N_OUT+N_IN-1:0] err_sum,
    output logic                  fail
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    localparam logic [N_OUT:0] ET_W = (N_OUT+1)'(ET);
    state_t state, state_nx;
    logic go, last, s1_valid;
    logic [N_OUT-1:0] s1_exact, s1_approx, err, new_max;
    assign go   = start && (state == IDLE || state == DONE);
    assign last = in_vec == '1;
    assign busy = state == SWEEP || state == DRAIN;
    assign done = state == DONE;
    always_comb begin
        state_nx = go ? SWEEP : state == SWEEP ? (last ? DRAIN : SWEEP) : state == DRAIN ? DONE : state;
        err      = s1_exact >= s1_approx ? s1_exact - s1_approx : s1_approx - s1_exact;
        new_max  = err > max_err ? err : max_err;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_vec    <= '0;
            s1_valid  <= 1'b0;
            s1_exact  <= '0;
            s1_approx <= '0;
            max_err   <= '0;
            err_count <= '0;
            err_sum   <= '0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nx;
            s1_valid  <= state == SWEEP;
            s1_exact  <= exact_val;
            s1_approx <= approx_val;
            if (go) begin
                in_vec    <= '0;
                max_err   <= '0;
                err_count <= '0;
                err_sum   <= '0;
                fail      <= 1'b0;
            end else begin
                if (state == SWEEP && !last) in_vec <= in_vec + 1'b1;
                // stage 2: commits the point captured on the previous edge
                if (s1_valid) begin
                    max_err   <= new_max;
                    err_count <= err_count + {{N_IN{1'b0}}, err != '0};
                    err_sum   <= err_sum + {{N_IN{1'b0}}, err};
                    fail      <= {1'b0, new_max} > ET_W;
                end
            end
        end
    end
endmodule

// File: tb/tb_approx_error_monitor.sv
// tb_approx_error_monitor: table-driven and randomized checks of the sweep statistics and timing.
module tb_approx_error_monitor;
    logic       clk = 0, rst_n = 0, start = 0;
    logic [3:0] in_vec;
    logic [2:0] exact_val, approx_val, max_err;
    logic       busy, done, fail;
    logic [4:0] err_count;
    logic [6:0] err_sum;
    logic [2:0] ex_tab [16];
    logic [2:0] ap_tab [16];
    int total = 0, bad = 0;

    typedef struct {
        int mode; int inj; int mx; int cnt; int sum; int fl;
    } vec_t;
    vec_t tbl [4];

    approx_error_monitor #(.N_IN(4), .N_OUT(3), .ET(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec),
        .exact_val(exact_val), .approx_val(approx_val), .busy(busy), .done(done),
        .max_err(max_err), .err_count(err_count), .err_sum(err_sum), .fail(fail)
    );

    always #5 clk = ~clk;
    assign exact_val  = ex_tab[in_vec];
    assign approx_val = ap_tab[in_vec];

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // mode 0: approx==exact; 1: approx=0; 2: approx=exact except +inj at point 5
    task automatic setup(input int mode, input int inj);
        for (int v = 0; v < 16; v++) begin
            int a, b, d;
            a = v & 3;
            b = (v >> 2) & 3;
            d = a > b ? a - b : b - a;
            ex_tab[v] = 3'(d);
            ap_tab[v] = mode == 1 ? 3'd0 : mode == 2 && v == 5 ? 3'(d + inj) : 3'(d);
        end
    endtask

    task automatic sweep(input bit hold, output int cyc, output int busy_n);
        start = 1;
        @(posedge clk); #1;
        if (!hold) start = 0;
        cyc = 1;
        busy_n = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic chk_stats(input string n, input int mx, input int cnt, input int sum, input int fl);
        chk({n, ".max_err"}, int'(max_err), mx);
        chk({n, ".err_count"}, int'(err_count), cnt);
        chk({n, ".err_sum"}, int'(err_sum), sum);
        chk({n, ".fail"}, int'(fail), fl);
    endtask

    initial begin
        int cyc, bn, mx, cnt, sum;
        tbl[0] = '{0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 3, 12, 20, 1};
        tbl[2] = '{2, 1, 1, 1, 1, 0};
        tbl[3] = '{2, 2, 2, 1, 2, 1};
        setup(0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.in_vec", int'(in_vec), 0);
        chk_stats("reset", 0, 0, 0, 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("idle.busy", int'(busy), 0);

        for (int i = 0; i < 4; i++) begin
            setup(tbl[i].mode, tbl[i].inj);
            sweep(0, cyc, bn);
            chk($sformatf("vec%0d.done_cycle", i), cyc, 18);
            chk($sformatf("vec%0d.busy_cycles", i), bn, 17);
            chk_stats($sformatf("vec%0d", i), tbl[i].mx, tbl[i].cnt, tbl[i].sum, tbl[i].fl);
        end

        // random tables against an arithmetic model
        for (int r = 0; r < 6; r++) begin
            mx = 0; cnt = 0; sum = 0;
            for (int v = 0; v < 16; v++) begin
                int e;
                ex_tab[v] = 3'($urandom_range(7));
                ap_tab[v] = ($urandom_range(1) == 1) ? ex_tab[v] : 3'($urandom_range(7));
                e = int'(ex_tab[v]) - int'(ap_tab[v]);
                if (e < 0) e = -e;
                if (e > mx) mx = e;
                if (e != 0) cnt++;
                sum += e;
            end
            sweep(0, cyc, bn);
            chk($sformatf("rnd%0d.done_cycle", r), cyc, 18);
            chk_stats($sformatf("rnd%0d", r), mx, cnt, sum, mx > 1 ? 1 : 0);
        end

        // mid-sweep reset
        setup(1, 0);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst9.busy_before", int'(busy), 1);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("rst9.busy", int'(busy), 0);
        chk("rst9.done", int'(done), 0);
        chk("rst9.in_vec", int'(in_vec), 0);
        chk_stats("rst9", 0, 0, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("rst9.idle_busy", int'(busy), 0);
        chk("rst9.idle_done", int'(done), 0);
        chk("rst9.idle_count", int'(err_count), 0);

        // start held high through the sweep and into DONE
        sweep(1, cyc, bn);
        chk("hold.done_cycle", cyc, 18);
        chk_stats("hold", 3, 12, 20, 1);
        @(posedge clk); #1;
        start = 0;
        chk("hold.restart_done", int'(done), 0);
        chk("hold.restart_busy", int'(busy), 1);
        chk("hold.restart_in_vec", int'(in_vec), 0);
        chk("hold.restart_count", int'(err_count), 0);
        chk("hold.restart_sum", int'(err_sum), 0);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold.second_done_cycle", cyc, 18);
        chk_stats("hold2", 3, 12, 20, 1);
        chk("hold.in_vec_final", int'(in_vec), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
